// File: rtl/incline_pkg.sv
// Shared widths and state encoding for the incline integrator.
//   RATE_W     : pitch-rate sample width
//   ACC_W      : integration accumulator width
//   INCL_W     : published incline width (accumulator MSBs)
//   SUM_W      : calibration sum width
//   LEAK_SHIFT : leak divisor exponent (only used with INCLINE_LEAK_EN)
package incline_pkg;

  localparam int unsigned RATE_W     = 16;
  localparam int unsigned ACC_W      = 27;
  localparam int unsigned INCL_W     = 13;
  localparam int unsigned SUM_W      = 20;
  localparam int unsigned LEAK_SHIFT = 10;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } state_e;

endpackage

// File: rtl/incline_integrator_if.sv
// Sample/result bundle of the incline integrator.
//   ptch_rt     : signed pitch-rate sample (master -> slave)
//   vld         : one-cycle strobe qualifying ptch_rt (master -> slave)
//   clr         : synchronous clear of integration/calibration (master -> slave)
//   incline     : signed integrated incline (slave -> master)
//   incline_vld : one-cycle pulse when incline updates (slave -> master)
//   cal_done    : high once calibration finished (slave -> master)
interface incline_integrator_if;

  logic signed [incline_pkg::RATE_W-1:0] ptch_rt;
  logic                                  vld;
  logic                                  clr;
  logic signed [incline_pkg::INCL_W-1:0] incline;
  logic                                  incline_vld;
  logic                                  cal_done;

  modport master (
    output ptch_rt, vld, clr,
    input  incline, incline_vld, cal_done
  );

  modport slave (
    input  ptch_rt, vld, clr,
    output incline, incline_vld, cal_done
  );

endinterface

// File: rtl/sat_add.sv
// Signed saturating adder: sum_o = clamp(a_i + b_i) to the W-bit signed range.
//   a_i, b_i : signed addends
//   sum_o    : saturated signed sum
module sat_add #(
  parameter int unsigned W = 27
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  logic [W:0] full;

  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    sum_o = full[W-1:0];
    // Extra sign bit disagreeing with the MSB means the W-bit result overflowed.
    if (full[W] != full[W-1]) begin
      sum_o = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/incline_integrator.sv
// Pitch-rate integrator with start-up bias calibration.
// CAL averages 2^CAL_LOG2 samples into an offset; RUN integrates (ptch_rt - offset)
// into a saturating accumulator whose MSBs are published as the incline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : incline_integrator_if slave (ptch_rt/vld/clr in, incline/incline_vld/cal_done out)
// Optional feature: define INCLINE_LEAK_EN to bleed acc >>> LEAK_SHIFT each RUN update.
module incline_integrator
  import incline_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  incline_integrator_if.slave  bus
);

  state_e                     state_q, state_d;
  logic [CAL_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d, sum_add;
  logic signed [RATE_W-1:0]   offset_q, offset_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_base, addend, acc_upd;
  logic signed [INCL_W-1:0]   incline_q, incline_d;
  logic                       ivld_q, ivld_d;
  logic [RATE_W:0]            diff;

  assign sum_add = sum_q + {{(SUM_W-RATE_W){bus.ptch_rt[RATE_W-1]}}, bus.ptch_rt};

  // One extra bit keeps the bias-corrected sample exact.
  assign diff   = {bus.ptch_rt[RATE_W-1], bus.ptch_rt} - {offset_q[RATE_W-1], offset_q};
  assign addend = {{(ACC_W-RATE_W-1){diff[RATE_W]}}, diff};

`ifdef INCLINE_LEAK_EN
  // Shrinks toward zero, so this subtraction can never overflow.
  assign acc_base = acc_q - (acc_q >>> LEAK_SHIFT);
`else
  assign acc_base = acc_q;
`endif

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a_i   (acc_base),
    .b_i   (addend),
    .sum_o (acc_upd)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    offset_d  = offset_q;
    acc_d     = acc_q;
    incline_d = incline_q;
    ivld_d    = 1'b0;
    if (bus.clr) begin
      // Clear wins over a coincident sample, which is dropped.
      if (state_q == CAL) begin
        sum_d = '0;
        cnt_d = '0;
      end else begin
        acc_d     = '0;
        incline_d = '0;
      end
    end else if (bus.vld) begin
      unique case (state_q)
        CAL: begin
          if (cnt_q == '1) begin
            offset_d = RATE_W'(sum_add >>> CAL_LOG2);
            sum_d    = '0;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            sum_d = sum_add;
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          acc_d     = acc_upd;
          incline_d = acc_upd[ACC_W-1 -: INCL_W];
          ivld_d    = 1'b1;
        end
        default: state_d = CAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CAL;
      cnt_q     <= '0;
      sum_q     <= '0;
      offset_q  <= '0;
      acc_q     <= '0;
      incline_q <= '0;
      ivld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      offset_q  <= offset_d;
      acc_q     <= acc_d;
      incline_q <= incline_d;
      ivld_q    <= ivld_d;
    end
  end

  assign bus.incline     = incline_q;
  assign bus.incline_vld = ivld_q;
  assign bus.cal_done    = (state_q == RUN);

endmodule

// File: tb/tb_incline_integrator.sv
// Self-checking bench for incline_integrator (default CAL_LOG2 = 4).
// Hand-computed expectations target the default build; with INCLINE_LEAK_EN the
// incline expectations come from a small reference accumulator instead.
module tb_incline_integrator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  incline_integrator_if bus ();

  incline_integrator #(
    .CAL_LOG2 (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference accumulator state
  logic signed [26:0] m_acc  = '0;
  int                 off_m  = 0;
  bit                 run_m  = 1'b0;

  typedef struct {
    logic               clr;
    logic               vld;
    int                 p;
    int                 inc;
    logic               ivld;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [26:0] mstep(input logic signed [26:0] a, input int d);
    longint t;
`ifdef INCLINE_LEAK_EN
    t = longint'(a) - (longint'(a) >>> 10) + longint'(d);
`else
    t = longint'(a) + longint'(d);
`endif
    if (t > 64'sd67108863) t = 64'sd67108863;
    if (t < -64'sd67108864) t = -64'sd67108864;
    return t[26:0];
  endfunction

  // Hand value in the default build, reference model value with the leak enabled.
  function automatic int expi(input int hand);
`ifdef INCLINE_LEAK_EN
    logic signed [12:0] s;
    s = m_acc[26:14];
    return int'(s);
`else
    return hand;
`endif
  endfunction

  task automatic feed(input logic c, input logic v, input int p);
    bus.clr     = c;
    bus.vld     = v;
    bus.ptch_rt = 16'(p);
    @(posedge clk);
    #1;
    if (run_m) begin
      if (c) m_acc = '0;
      else if (v) m_acc = mstep(m_acc, p - off_m);
    end
  endtask

  task automatic do_reset();
    bus.clr = 1'b0;
    bus.vld = 1'b0;
    rst     = 1'b1;
    run_m   = 1'b0;
    m_acc   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs 16 calibration samples, checking CAL behaviour on every cycle.
  task automatic calibrate(input int p, input string tag);
    for (int i = 0; i < 16; i++) begin
      feed(1'b0, 1'b1, p);
      if (i < 15) begin
        chk({tag, " cal_done during CAL"}, 32'(bus.cal_done), 0);
        chk({tag, " incline_vld during CAL"}, 32'(bus.incline_vld), 0);
      end
    end
    feed(1'b0, 1'b0, 0);
    chk({tag, " cal_done after 16"}, 32'(bus.cal_done), 1);
    chk({tag, " incline after cal"}, $signed(bus.incline), 0);
    off_m = p;
    m_acc = '0;
    run_m = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic neg_seen;
    bus.clr     = 1'b0;
    bus.vld     = 1'b0;
    bus.ptch_rt = '0;

    // Offset 100; acc starts at 0. incline = floor(acc / 16384).
    vecs[0] = '{1'b0, 1'b1,  16484,  1, 1'b1};  // acc 16384
    vecs[1] = '{1'b0, 1'b0,      0,  1, 1'b0};  // idle: single-cycle pulse
    vecs[2] = '{1'b0, 1'b1,    100,  1, 1'b1};  // sample == offset
    vecs[3] = '{1'b0, 1'b1,  16484,  2, 1'b1};  // back-to-back, acc 32768
    vecs[4] = '{1'b0, 1'b1, -16284,  1, 1'b1};  // acc 16384
    vecs[5] = '{1'b0, 1'b1, -32668, -1, 1'b1};  // acc -16384
    vecs[6] = '{1'b1, 1'b1,   5000,  0, 1'b0};  // clr beats vld
    vecs[7] = '{1'b0, 1'b1,      0, -1, 1'b1};  // acc -100
    vecs[8] = '{1'b1, 1'b0,      0,  0, 1'b0};  // clr alone
    vecs[9] = '{1'b0, 1'b1, -32768, -3, 1'b1};  // acc -32868

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset incline", $signed(bus.incline), 0);
    chk("reset incline_vld", 32'(bus.incline_vld), 0);
    chk("reset cal_done", 32'(bus.cal_done), 0);
    rst = 1'b0;

    calibrate(100, "cal100");

    for (int i = 0; i < 10; i++) begin
      feed(vecs[i].clr, vecs[i].vld, vecs[i].p);
      chk($sformatf("vec%0d incline", i), $signed(bus.incline), expi(vecs[i].inc));
      chk($sformatf("vec%0d incline_vld", i), 32'(bus.incline_vld), 32'(vecs[i].ivld));
      chk($sformatf("vec%0d cal_done", i), 32'(bus.cal_done), 1);
    end

    // Asynchronous reset mid-run: outputs drop between clock edges.
    for (int i = 0; i < 4; i++) feed(1'b0, 1'b1, 16484);  // acc 32668
    chk("prerst incline", $signed(bus.incline), expi(1));
    bus.vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst incline", $signed(bus.incline), 0);
    chk("async rst incline_vld", 32'(bus.incline_vld), 0);
    chk("async rst cal_done", 32'(bus.cal_done), 0);
    do_reset();

    // Reset after 8 calibration samples discards the partial sum.
    for (int i = 0; i < 8; i++) feed(1'b0, 1'b1, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("midcal rst cal_done", 32'(bus.cal_done), 0);
    do_reset();
    for (int i = 0; i < 15; i++) feed(1'b0, 1'b1, 0);
    chk("midcal 15 fresh cal_done", 32'(bus.cal_done), 0);
    feed(1'b0, 1'b1, 0);
    chk("midcal 16 fresh cal_done", 32'(bus.cal_done), 1);
    off_m = 0;
    m_acc = '0;
    run_m = 1'b1;
    feed(1'b0, 1'b1, 16384);  // stale sum would give offset 50 and incline 0
    chk("midcal offset zero", $signed(bus.incline), expi(1));

    // clr in CAL restarts calibration (sample on the clr cycle is dropped).
    do_reset();
    for (int i = 0; i < 8; i++) feed(1'b0, 1'b1, 1000);
    feed(1'b1, 1'b1, 1000);
    for (int i = 0; i < 15; i++) feed(1'b0, 1'b1, 0);
    chk("calclr 15 cal_done", 32'(bus.cal_done), 0);
    feed(1'b0, 1'b1, 0);
    chk("calclr 16 cal_done", 32'(bus.cal_done), 1);
    off_m = 0;
    m_acc = '0;
    run_m = 1'b1;
    feed(1'b0, 1'b1, 16384);
    chk("calclr offset zero", $signed(bus.incline), expi(1));

    // Leak check: build acc to 2^20, then a zero-rate sample.
    feed(1'b1, 1'b0, 0);
    chk("run clr cal_done", 32'(bus.cal_done), 1);
    for (int i = 0; i < 64; i++) feed(1'b0, 1'b1, 16384);
    chk("leak build incline", $signed(bus.incline), expi(64));
    feed(1'b0, 1'b1, 0);
    chk("leak step incline", $signed(bus.incline), expi(64));

    // Positive saturation: incline climbs to 4095 and never wraps.
    feed(1'b1, 1'b0, 0);
    neg_seen = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      feed(1'b0, 1'b1, 32767);
      if (bus.incline[12]) neg_seen = 1'b1;
    end
    chk("sat pos no wrap", 32'(neg_seen), 0);
    chk("sat pos incline", $signed(bus.incline), expi(4095));
    for (int i = 0; i < 5; i++) feed(1'b0, 1'b1, 32767);
    chk("sat pos hold", $signed(bus.incline), expi(4095));
    feed(1'b0, 1'b0, 0);
    chk("sat pos idle incline_vld", 32'(bus.incline_vld), 0);

    // Negative saturation.
    feed(1'b1, 1'b0, 0);
    for (int i = 0; i < 2100; i++) feed(1'b0, 1'b1, -32768);
    chk("sat neg incline", $signed(bus.incline), expi(-4096));
    feed(1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
